// File: rtl/wb_bus_controller.sv
// Wishbone master-to-slave bus controller: decodes one master onto bootrom, RAM and IO slaves.
// Handles one outstanding transaction, with a bus error on unmapped addresses or slave timeout.
module wb_bus_controller #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic        o_wb_stall,
   output logic [31:0] o_s_addr,
   output logic [31:0] o_s_data,
   output logic        o_s_we,
   output logic [2:0]  o_s_cyc,
   output logic [2:0]  o_s_stb,
   input  logic [31:0] i_s_data0,
   input  logic [31:0] i_s_data1,
   input  logic [31:0] i_s_data2,
   input  logic [2:0]  i_s_ack,
   input  logic [2:0]  i_s_stall
);

   localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   // The counter equals the number of WAIT cycles already spent, so the
   // last permitted WAIT cycle is the one where it reads TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       sel_idx;
   logic [1:0]       dec_idx;
   logic             dec_hit;
   logic             dec_stall;
   logic [CNT_W-1:0] tmo_cnt;
   logic             req;
   logic             accept;
   logic             sel_ack;
   logic [31:0]      sel_data;

   assign o_s_addr = i_wb_addr;
   assign o_s_data = i_wb_data;
   assign o_s_we   = i_wb_we;
   assign req      = i_wb_cyc & i_wb_stb;

   always_comb begin
      dec_hit   = 1'b1;
      dec_idx   = 2'd0;
      dec_stall = 1'b0;
      if (i_wb_addr[31:15] == 17'h16000) begin
         dec_idx = 2'd0;
      end else if (i_wb_addr[31:15] == 17'h16001) begin
         dec_idx = 2'd1;
      end else if (i_wb_addr[31:16] == 16'hc000) begin
         dec_idx = 2'd2;
      end else begin
         dec_hit = 1'b0;
      end
      case (dec_idx)
         2'd0:    dec_stall = dec_hit & i_s_stall[0];
         2'd1:    dec_stall = dec_hit & i_s_stall[1];
         2'd2:    dec_stall = dec_hit & i_s_stall[2];
         default: dec_stall = 1'b0;
      endcase
   end

   always_comb begin
      sel_ack  = 1'b0;
      sel_data = 32'h0;
      case (sel_idx)
         2'd0: begin sel_ack = i_s_ack[0]; sel_data = i_s_data0; end
         2'd1: begin sel_ack = i_s_ack[1]; sel_data = i_s_data1; end
         2'd2: begin sel_ack = i_s_ack[2]; sel_data = i_s_data2; end
         default: begin sel_ack = 1'b0; sel_data = 32'h0; end
      endcase
   end

   always_comb begin
      state_next = state;
      o_wb_stall = 1'b0;
      o_wb_err   = 1'b0;
      o_s_cyc    = 3'b000;
      o_s_stb    = 3'b000;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            o_wb_stall = dec_stall;
            if (dec_hit) begin
               o_s_cyc[dec_idx] = req;
               o_s_stb[dec_idx] = req;
            end
            accept = req & ~dec_stall;
            if (accept) begin
               state_next = dec_hit ? WAIT : ERR;
            end
         end
         WAIT: begin
            o_wb_stall       = 1'b1;
            o_s_cyc[sel_idx] = 1'b1;
            // Abort beats ack, and ack beats timeout.
            if (!i_wb_cyc) begin
               state_next = IDLE;
            end else if (sel_ack) begin
               state_next = IDLE;
            end else if (tmo_cnt == CNT_LAST) begin
               state_next = ERR;
            end
         end
         ERR: begin
            o_wb_stall = 1'b1;
            o_wb_err   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (reset) begin
         o_s_cyc = 3'b000;
         o_s_stb = 3'b000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         sel_idx   <= 2'd0;
         o_wb_ack  <= 1'b0;
         o_wb_data <= 32'h0;
      end else begin
         state    <= state_next;
         o_wb_ack <= 1'b0;
         if (state == IDLE && accept && dec_hit) begin
            sel_idx <= dec_idx;
            tmo_cnt <= '0;
         end
         if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (i_wb_cyc && sel_ack) begin
               o_wb_data <= sel_data;
               o_wb_ack  <= 1'b1;
            end
         end
      end
   end

endmodule
